// File: rtl/msgpass_rd_sched_pkg.sv
// Shared definitions for the message-pass read scheduler.
//   memShare_config_pkg : memory-share configuration (DRC select width).
//   msgPass_sched_pkg   : scheduler state encoding, default counter widths,
//                         and DRC_NUM re-exported from memShare_config_pkg.
package memShare_config_pkg;
  localparam int MEMSHARE_DRC_NUM = 2;
endpackage

package msgPass_sched_pkg;
  localparam int DRC_NUM       = memShare_config_pkg::MEMSHARE_DRC_NUM;
  localparam int LAYER_MAX_DEF = 4;
  localparam int ROW_NUM_DEF   = 8;
  localparam int LAYER_W       = $clog2(LAYER_MAX_DEF + 1);
  localparam int ROW_W         = $clog2(ROW_NUM_DEF);

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_BEGIN,
    SCH_READ,
    SCH_END,
    SCH_GAP,
    SCH_DONE
  } sched_state_t;
endpackage

// File: rtl/msgpass_gap_timer.sv
// Loadable down-counter that times the idle gap between layers.
// Ports:
//   sys_clk    : clock, posedge
//   rst        : synchronous active-high reset
//   load_i     : pulse; start a new count from load_val_i
//   load_val_i : cycles-1 to run before expiring
//   expire_o   : high during the final cycle of a loaded count
module msgpass_gap_timer
  import msgPass_sched_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  // A loaded value of N-1 yields expiry on the N-th cycle after the load.
  assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/msgpass_rd_sched.sv
// Layer-by-layer sequencer for the message-pass buffer read address generator.
// Per layer: read-begin pulse, ROW_NUM row beats paced by stall_i, read-end
// pulse, then a GAP_CYC idle gap before the next layer.
// Ports:
//   sys_clk, rst          : clock and synchronous active-high reset
//   start_i               : pulse, begin an iteration
//   layer_num_i           : layers this iteration (0 = no-op, clamped to LAYER_MAX)
//   drc_cfg_i             : per-layer DRC select, layer k at [k*DRC_NUM +: DRC_NUM]
//   stall_i               : downstream not ready, freezes row advance in READ
//   buffer_read_begin_o   : pulse, first cycle of each layer
//   buffer_read_end_o     : pulse, cycle after the last row beat of a layer
//   is_drc_o              : DRC select of the current layer
//   rd_valid_o            : row beat issued this cycle
//   layer_idx_o/row_idx_o : current layer / row
//   busy_o                : iteration in progress (BEGIN..DONE)
//   done_o                : pulse, iteration complete
//   err_o                 : sticky; start while busy or layer count clamped
module msgpass_rd_sched
  import msgPass_sched_pkg::*;
#(
  parameter  int LAYER_MAX = 4,
  parameter  int ROW_NUM   = 8,
  parameter  int DRC_NUM   = msgPass_sched_pkg::DRC_NUM,
  parameter  int GAP_CYC   = 2,
  localparam int LAYER_W   = $clog2(LAYER_MAX + 1),
  localparam int ROW_W     = $clog2(ROW_NUM),
  localparam int GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [LAYER_W-1:0]           layer_num_i,
  input  logic [LAYER_MAX*DRC_NUM-1:0] drc_cfg_i,
  input  logic                         stall_i,
  output logic                         buffer_read_begin_o,
  output logic                         buffer_read_end_o,
  output logic [DRC_NUM-1:0]           is_drc_o,
  output logic                         rd_valid_o,
  output logic [LAYER_W-1:0]           layer_idx_o,
  output logic [ROW_W-1:0]             row_idx_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  sched_state_t                 state_q;
  logic [LAYER_W-1:0]           layer_num_q;
  logic [LAYER_MAX*DRC_NUM-1:0] cfg_q;
  logic [LAYER_W-1:0]           layer_q;
  logic [ROW_W-1:0]             row_q;
  logic [DRC_NUM-1:0]           drc_q;
  logic                         err_q;
  logic                         noop_done_q;
  logic                         last_layer;
  logic                         gap_load;
  logic                         gap_expire;

  assign last_layer = (layer_q == layer_num_q - 1'b1);
  assign gap_load   = (state_q == SCH_END) && !last_layer;

  msgpass_gap_timer #(
    .CNT_W (GAP_W)
  ) u_gap_timer (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(GAP_CYC - 1)),
    .expire_o   (gap_expire)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= SCH_IDLE;
      layer_num_q <= '0;
      cfg_q       <= '0;
      layer_q     <= '0;
      row_q       <= '0;
      drc_q       <= '0;
      err_q       <= 1'b0;
      noop_done_q <= 1'b0;
    end else begin
      noop_done_q <= 1'b0;
      // Any start outside IDLE (including the DONE cycle) is dropped and flagged.
      if (start_i && (state_q != SCH_IDLE)) err_q <= 1'b1;
      case (state_q)
        SCH_IDLE: begin
          if (start_i) begin
            if (layer_num_i == '0) begin
              noop_done_q <= 1'b1;
            end else begin
              if (layer_num_i > LAYER_W'(LAYER_MAX)) begin
                layer_num_q <= LAYER_W'(LAYER_MAX);
                err_q       <= 1'b1;
              end else begin
                layer_num_q <= layer_num_i;
              end
              cfg_q   <= drc_cfg_i;
              layer_q <= '0;
              row_q   <= '0;
              drc_q   <= drc_cfg_i[DRC_NUM-1:0];
              state_q <= SCH_BEGIN;
            end
          end
        end
        SCH_BEGIN: state_q <= SCH_READ;
        SCH_READ: begin
          if (!stall_i) begin
            if (row_q == ROW_W'(ROW_NUM - 1)) state_q <= SCH_END;
            else                              row_q   <= row_q + 1'b1;
          end
        end
        SCH_END: begin
          if (last_layer) begin
            layer_q <= '0;
            row_q   <= '0;
            state_q <= SCH_DONE;
          end else begin
            layer_q <= layer_q + 1'b1;
            drc_q   <= '0;
            state_q <= SCH_GAP;
          end
        end
        SCH_GAP: begin
          if (gap_expire) begin
            row_q   <= '0;
            drc_q   <= cfg_q[layer_q*DRC_NUM +: DRC_NUM];
            state_q <= SCH_BEGIN;
          end
        end
        SCH_DONE: state_q <= SCH_IDLE;
        default:  state_q <= SCH_IDLE;
      endcase
    end
  end

  assign buffer_read_begin_o = (state_q == SCH_BEGIN);
  assign buffer_read_end_o   = (state_q == SCH_END);
  assign rd_valid_o          = (state_q == SCH_READ) && !stall_i;
  assign busy_o              = (state_q != SCH_IDLE);
  assign done_o              = (state_q == SCH_DONE) || noop_done_q;
  assign is_drc_o            = drc_q;
  assign layer_idx_o         = layer_q;
  assign row_idx_o           = row_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_msgpass_rd_sched.sv
module tb_msgpass_rd_sched;

  localparam int LMAX = 4;
  localparam int ROWS = 8;
  localparam int GAP  = 2;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [2:0] layer_num_i = '0;
  logic [7:0] drc_cfg_i = '0;
  logic       stall_i = 1'b0;
  logic       buffer_read_begin_o, buffer_read_end_o, rd_valid_o, busy_o, done_o, err_o;
  logic [1:0] is_drc_o;
  logic [2:0] layer_idx_o, row_idx_o;

  msgpass_rd_sched dut (
    .sys_clk             (sys_clk),
    .rst                 (rst),
    .start_i             (start_i),
    .layer_num_i         (layer_num_i),
    .drc_cfg_i           (drc_cfg_i),
    .stall_i             (stall_i),
    .buffer_read_begin_o (buffer_read_begin_o),
    .buffer_read_end_o   (buffer_read_end_o),
    .is_drc_o            (is_drc_o),
    .rd_valid_o          (rd_valid_o),
    .layer_idx_o         (layer_idx_o),
    .row_idx_o           (row_idx_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .err_o               (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event recorder: cycle numbers of pulses, DRC at each begin, beat/busy counts.
  int begin_q[$];
  int end_q[$];
  int done_q[$];
  int drc_q[$];
  int n_beat = 0;
  int n_busy = 0;
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (buffer_read_begin_o === 1'b1) begin begin_q.push_back(cyc); drc_q.push_back(int'(is_drc_o)); end
      if (buffer_read_end_o === 1'b1) end_q.push_back(cyc);
      if (done_o === 1'b1) done_q.push_back(cyc);
      if (rd_valid_o === 1'b1) n_beat++;
      if (busy_o === 1'b1) n_busy++;
    end
  end

  // Reference model: walks an iteration as nested loops over layers and rows.
  logic       exp_begin = 0, exp_end = 0, exp_inread = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
  logic [1:0] exp_drc = '0;
  logic [2:0] exp_layer = '0, exp_row = '0;

  task automatic m_clear();
    exp_begin = 0; exp_end = 0; exp_inread = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
    exp_drc = '0; exp_layer = '0; exp_row = '0;
  endtask

  task automatic tick(output bit ab);
    @(posedge sys_clk);
    ab = rst;
    if (rst) m_clear();
    else if (start_i && exp_busy) exp_err = 1;
  endtask

  task automatic run_iter(input int n, input logic [7:0] cfg);
    bit ab;
    int r;
    for (int l = 0; l < n; l++) begin
      exp_begin = 1; exp_busy = 1; exp_layer = 3'(l); exp_row = '0;
      exp_drc = cfg[2*l +: 2]; exp_inread = 0;
      tick(ab); if (ab) return;
      exp_begin = 0; exp_inread = 1; r = 0;
      while (r < ROWS) begin
        exp_row = 3'(r);
        tick(ab); if (ab) return;
        if (!stall_i) r++;
      end
      exp_inread = 0; exp_end = 1;
      tick(ab); if (ab) return;
      exp_end = 0;
      if (l == n - 1) begin
        exp_done = 1; exp_layer = '0; exp_row = '0;
        tick(ab); if (ab) return;
        exp_done = 0; exp_busy = 0;
      end else begin
        exp_layer = 3'(l + 1); exp_drc = '0;
        repeat (GAP) begin tick(ab); if (ab) return; end
      end
    end
  endtask

  initial begin : model
    bit ab;
    int n;
    logic [7:0] cfg;
    m_clear();
    forever begin
      tick(ab);
      if (!ab) begin
        exp_done = 0;
        if (start_i) begin
          if (layer_num_i == 0) begin
            exp_done = 1;
          end else begin
            n = (int'(layer_num_i) > LMAX) ? LMAX : int'(layer_num_i);
            if (int'(layer_num_i) > LMAX) exp_err = 1;
            cfg = drc_cfg_i;
            run_iter(n, cfg);
          end
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic compare_loop();
    logic exp_rdv;
    forever begin
      @(negedge sys_clk);
      if (cmp_en) begin
        exp_rdv = exp_inread && !stall_i;
        n_tests++;
        if (buffer_read_begin_o !== exp_begin || buffer_read_end_o !== exp_end ||
            is_drc_o !== exp_drc || rd_valid_o !== exp_rdv || layer_idx_o !== exp_layer ||
            row_idx_o !== exp_row || busy_o !== exp_busy || done_o !== exp_done || err_o !== exp_err) begin
          n_fail++;
          $display("FAIL cycle %0d outputs: got beg=%b end=%b drc=%b rdv=%b lay=%0d row=%0d busy=%b done=%b err=%b, expected beg=%b end=%b drc=%b rdv=%b lay=%0d row=%0d busy=%b done=%b err=%b",
                   cyc, buffer_read_begin_o, buffer_read_end_o, is_drc_o, rd_valid_o, layer_idx_o,
                   row_idx_o, busy_o, done_o, err_o, exp_begin, exp_end, exp_drc, exp_rdv,
                   exp_layer, exp_row, exp_busy, exp_done, exp_err);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic pulse_start(input int ln, input logic [7:0] cfg, output int t);
    layer_num_i = 3'(ln);
    drc_cfg_i   = cfg;
    start_i     = 1'b1;
    t           = cyc;
    step();
    start_i     = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_outs"}, int'({buffer_read_begin_o, buffer_read_end_o, is_drc_o, rd_valid_o,
                              layer_idx_o, row_idx_o, busy_o, done_o, err_o}), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    int t, b0, e0, d0, v0, u0;
    b0 = begin_q.size(); e0 = end_q.size(); d0 = done_q.size(); v0 = n_beat; u0 = n_busy;
    pulse_start(1, 8'h03, t);
    repeat (14) step();
    check({tag, "_nbegin"}, begin_q.size() - b0, 1);
    check({tag, "_begin_cyc"}, qat(begin_q, b0), t + 1);
    check({tag, "_drc"}, qat(drc_q, b0), 3);
    check({tag, "_beats"}, n_beat - v0, 8);
    check({tag, "_end_cyc"}, qat(end_q, e0), t + 10);
    check({tag, "_done_cyc"}, qat(done_q, d0), t + 11);
    check({tag, "_ndone"}, done_q.size() - d0, 1);
    check({tag, "_busy_cycles"}, n_busy - u0, 11);
  endtask

  task automatic stimulus();
    int t, b0, e0, d0, v0, u0;
    step();
    cmp_en = 1;
    step(); step();
    rst = 1'b0;
    check_zero("reset");
    step();

    // T1: single layer, no stall
    run_t1("t1");

    // T2: three layers with distinct DRC selects
    b0 = begin_q.size(); e0 = end_q.size(); d0 = done_q.size(); u0 = n_busy;
    pulse_start(3, 8'h09, t);
    repeat (40) step();
    check("t2_nbegin", begin_q.size() - b0, 3);
    check("t2_nend", end_q.size() - e0, 3);
    check("t2_begin1_cyc", qat(begin_q, b0 + 1), t + 13);
    check("t2_begin2_cyc", qat(begin_q, b0 + 2), t + 25);
    check("t2_end2_cyc", qat(end_q, e0 + 2), t + 34);
    check("t2_drc0", qat(drc_q, b0), 1);
    check("t2_drc1", qat(drc_q, b0 + 1), 2);
    check("t2_drc2", qat(drc_q, b0 + 2), 0);
    check("t2_done_cyc", qat(done_q, d0), t + 35);
    check("t2_busy_cycles", n_busy - u0, 35);

    // T3: stall 3 cycles at row 4 and 1 cycle at row 7
    e0 = end_q.size(); d0 = done_q.size(); v0 = n_beat;
    pulse_start(1, 8'h02, t);
    repeat (5) step();
    stall_i = 1'b1;
    step();
    check("t3_row_hold", int'(row_idx_o), 4);
    check("t3_rdv_stalled", int'(rd_valid_o), 0);
    step(); step();
    stall_i = 1'b0;
    repeat (3) step();
    stall_i = 1'b1;
    step();
    stall_i = 1'b0;
    repeat (6) step();
    check("t3_beats", n_beat - v0, 8);
    check("t3_end_cyc", qat(end_q, e0), t + 14);
    check("t3_done_cyc", qat(done_q, d0), t + 15);

    // T4: start again mid-READ
    b0 = begin_q.size(); e0 = end_q.size(); d0 = done_q.size();
    pulse_start(1, 8'h01, t);
    repeat (3) step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("t4_err_set", int'(err_o), 1);
    repeat (12) step();
    check("t4_nbegin", begin_q.size() - b0, 1);
    check("t4_end_cyc", qat(end_q, e0), t + 10);
    check("t4_done_cyc", qat(done_q, d0), t + 11);
    check("t4_ndone", done_q.size() - d0, 1);
    check("t4_err_sticky", int'(err_o), 1);

    // T5: zero-layer no-op, then clamped layer count
    do_reset();
    check_zero("t5_reset");
    b0 = begin_q.size(); d0 = done_q.size(); u0 = n_busy;
    pulse_start(0, 8'h00, t);
    repeat (3) step();
    check("t5_noop_done_cyc", qat(done_q, d0), t + 1);
    check("t5_noop_nbegin", begin_q.size() - b0, 0);
    check("t5_noop_busy", n_busy - u0, 0);
    check("t5_noop_err", int'(err_o), 0);
    b0 = begin_q.size(); e0 = end_q.size(); d0 = done_q.size();
    pulse_start(7, 8'hE4, t);
    repeat (50) step();
    check("t5_clamp_nbegin", begin_q.size() - b0, 4);
    check("t5_clamp_nend", end_q.size() - e0, 4);
    check("t5_clamp_drc3", qat(drc_q, b0 + 3), 3);
    check("t5_clamp_done_cyc", qat(done_q, d0), t + 47);
    check("t5_clamp_err", int'(err_o), 1);

    // T6: reset during layer 1 READ, then a fresh single-layer run
    do_reset();
    e0 = end_q.size();
    pulse_start(2, 8'h09, t);
    repeat (15) step();
    check("t6_in_layer1", int'(layer_idx_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("t6_abort");
    repeat (5) step();
    check("t6_nend", end_q.size() - e0, 1);
    run_t1("t6_fresh");
    repeat (3) step();
  endtask

  initial begin
    fork
      compare_loop();
      stimulus();
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
